rs_alu_station: RTL and testbench

//  Reservation station for the integer/branch unit in the Tomasulo core. Accepts

---
 rtl/rs_alu_station.sv | 225 ++++++++++++++++++++++
 tb/tb_rs_alu_station.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_alu_station.sv
// rs_alu_station: reservation station for the integer/branch unit.
// Holds renamed instructions, snoops the ALU and LSB result buses to fill
// pending operands, and issues the lowest-index ready entry to the ALU
// through a registered ex_* stage.
// Optional feature macro: RS_SAME_CYCLE_WAKE_EN -- when defined, an entry whose
// last pending operand arrives on a CDB this cycle may issue on the same edge.
module rs_alu_station #(
    parameter int RS_SIZE = 16,
    parameter int TAG_W   = 4,
    parameter int TYPE_W  = 6,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [TYPE_W-1:0] in_type,
    input  logic [DATA_W-1:0] in_vj,
    input  logic [DATA_W-1:0] in_vk,
    input  logic              in_qj_busy,
    input  logic [TAG_W-1:0]  in_qj,
    input  logic              in_qk_busy,
    input  logic [TAG_W-1:0]  in_qk,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [TAG_W-1:0]  in_dest,
    output logic              full,
    input  logic              alu_cdb_v,
    input  logic [TAG_W-1:0]  alu_cdb_tag,
    input  logic [DATA_W-1:0] alu_cdb_val,
    input  logic              lsb_cdb_v,
    input  logic [TAG_W-1:0]  lsb_cdb_tag,
    input  logic [DATA_W-1:0] lsb_cdb_val,
    output logic              ex_valid,
    output logic [TYPE_W-1:0] ex_type,
    output logic [DATA_W-1:0] ex_vj,
    output logic [DATA_W-1:0] ex_vk,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_pc,
    output logic [TAG_W-1:0]  ex_dest
);
    localparam int IDX_W = $clog2(RS_SIZE);

    // Entry state
    logic [RS_SIZE-1:0] busy_q, busy_d, qj_pend_q, qj_pend_d, qk_pend_q, qk_pend_d;
    logic [TYPE_W-1:0]  type_q [RS_SIZE];
    logic [TYPE_W-1:0]  type_d [RS_SIZE];
    logic [DATA_W-1:0]  vj_q [RS_SIZE];
    logic [DATA_W-1:0]  vj_d [RS_SIZE];
    logic [DATA_W-1:0]  vk_q [RS_SIZE];
    logic [DATA_W-1:0]  vk_d [RS_SIZE];
    logic [DATA_W-1:0]  a_q [RS_SIZE];
    logic [DATA_W-1:0]  a_d [RS_SIZE];
    logic [DATA_W-1:0]  pc_q [RS_SIZE];
    logic [DATA_W-1:0]  pc_d [RS_SIZE];
    logic [TAG_W-1:0]   qj_q [RS_SIZE];
    logic [TAG_W-1:0]   qj_d [RS_SIZE];
    logic [TAG_W-1:0]   qk_q [RS_SIZE];
    logic [TAG_W-1:0]   qk_d [RS_SIZE];
    logic [TAG_W-1:0]   dest_q [RS_SIZE];
    logic [TAG_W-1:0]   dest_d [RS_SIZE];

    // Issue stage registers
    logic              ex_valid_q, ex_valid_d;
    logic [TYPE_W-1:0] ex_type_q, ex_type_d;
    logic [DATA_W-1:0] ex_vj_q, ex_vj_d, ex_vk_q, ex_vk_d, ex_a_q, ex_a_d, ex_pc_q, ex_pc_d;
    logic [TAG_W-1:0]  ex_dest_q, ex_dest_d;

    // Snoop results and selection
    logic               alu_v, lsb_v, accept;
    logic [DATA_W-1:0]  cap_vj [RS_SIZE];
    logic [DATA_W-1:0]  cap_vk [RS_SIZE];
    logic [RS_SIZE-1:0] cap_jp, cap_kp, ready;
    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx, free_idx;
    logic [DATA_W-1:0]  byp_vj, byp_vk;
    logic               byp_jp, byp_kp;

    // The buses are only meaningful while the core is enabled.
    assign alu_v  = alu_cdb_v & rdy;
    assign lsb_v  = lsb_cdb_v & rdy;
    assign full   = &busy_q;
    assign accept = in_valid & ~full & rdy & ~clear;

    // Per-entry operand capture from both CDBs (ALU bus has priority on equal tags)
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            cap_vj[i] = vj_q[i];
            cap_jp[i] = qj_pend_q[i];
            cap_vk[i] = vk_q[i];
            cap_kp[i] = qk_pend_q[i];
            if (busy_q[i] && qj_pend_q[i]) begin
                if (alu_v && alu_cdb_tag == qj_q[i]) begin
                    cap_vj[i] = alu_cdb_val;
                    cap_jp[i] = 1'b0;
                end else if (lsb_v && lsb_cdb_tag == qj_q[i]) begin
                    cap_vj[i] = lsb_cdb_val;
                    cap_jp[i] = 1'b0;
                end
            end
            if (busy_q[i] && qk_pend_q[i]) begin
                if (alu_v && alu_cdb_tag == qk_q[i]) begin
                    cap_vk[i] = alu_cdb_val;
                    cap_kp[i] = 1'b0;
                end else if (lsb_v && lsb_cdb_tag == qk_q[i]) begin
                    cap_vk[i] = lsb_cdb_val;
                    cap_kp[i] = 1'b0;
                end
            end
        end
    end

    // Readiness: either from the registered pend bits or including this cycle's capture
    generate
        for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_ready
`ifdef RS_SAME_CYCLE_WAKE_EN
            assign ready[gi] = busy_q[gi] & ~cap_jp[gi] & ~cap_kp[gi];
`else
            assign ready[gi] = busy_q[gi] & ~qj_pend_q[gi] & ~qk_pend_q[gi];
`endif
        end
    endgenerate

    // Lowest-index ready entry and lowest-index free entry
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        free_idx  = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
            if (!busy_q[i]) free_idx = IDX_W'(i);
        end
    end

    // Dispatch bypass: an operand whose producer broadcasts this cycle is taken directly
    always_comb begin
        byp_vj = in_vj;
        byp_jp = in_qj_busy;
        byp_vk = in_vk;
        byp_kp = in_qk_busy;
        if (in_qj_busy && alu_v && alu_cdb_tag == in_qj) begin
            byp_vj = alu_cdb_val;
            byp_jp = 1'b0;
        end else if (in_qj_busy && lsb_v && lsb_cdb_tag == in_qj) begin
            byp_vj = lsb_cdb_val;
            byp_jp = 1'b0;
        end
        if (in_qk_busy && alu_v && alu_cdb_tag == in_qk) begin
            byp_vk = alu_cdb_val;
            byp_kp = 1'b0;
        end else if (in_qk_busy && lsb_v && lsb_cdb_tag == in_qk) begin
            byp_vk = lsb_cdb_val;
            byp_kp = 1'b0;
        end
    end

    // Next state: flush, else (when enabled) capture, issue and accept
    always_comb begin
        busy_d = busy_q;  qj_pend_d = qj_pend_q;  qk_pend_d = qk_pend_q;
        type_d = type_q;  vj_d = vj_q;  vk_d = vk_q;  a_d = a_q;  pc_d = pc_q;
        qj_d = qj_q;  qk_d = qk_q;  dest_d = dest_q;
        ex_valid_d = ex_valid_q;  ex_type_d = ex_type_q;  ex_vj_d = ex_vj_q;
        ex_vk_d = ex_vk_q;  ex_a_d = ex_a_q;  ex_pc_d = ex_pc_q;  ex_dest_d = ex_dest_q;
        if (clear) begin
            busy_d     = '0;
            ex_valid_d = 1'b0;
        end else if (rdy) begin
            vj_d = cap_vj;  vk_d = cap_vk;  qj_pend_d = cap_jp;  qk_pend_d = cap_kp;
            ex_valid_d = sel_found;
            if (sel_found) begin
                ex_type_d       = type_q[sel_idx];
                ex_vj_d         = cap_vj[sel_idx];
                ex_vk_d         = cap_vk[sel_idx];
                ex_a_d          = a_q[sel_idx];
                ex_pc_d         = pc_q[sel_idx];
                ex_dest_d       = dest_q[sel_idx];
                busy_d[sel_idx] = 1'b0;
            end
            if (accept) begin
                busy_d[free_idx]    = 1'b1;
                type_d[free_idx]    = in_type;
                vj_d[free_idx]      = byp_vj;
                vk_d[free_idx]      = byp_vk;
                qj_pend_d[free_idx] = byp_jp;
                qk_pend_d[free_idx] = byp_kp;
                qj_d[free_idx]      = in_qj;
                qk_d[free_idx]      = in_qk;
                a_d[free_idx]       = in_a;
                pc_d[free_idx]      = in_pc;
                dest_d[free_idx]    = in_dest;
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;  qj_pend_q <= '0;  qk_pend_q <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                type_q[i] <= '0;  vj_q[i] <= '0;  vk_q[i] <= '0;  a_q[i] <= '0;
                pc_q[i] <= '0;  qj_q[i] <= '0;  qk_q[i] <= '0;  dest_q[i] <= '0;
            end
            ex_valid_q <= 1'b0;  ex_type_q <= '0;  ex_vj_q <= '0;  ex_vk_q <= '0;
            ex_a_q <= '0;  ex_pc_q <= '0;  ex_dest_q <= '0;
        end else begin
            busy_q <= busy_d;  qj_pend_q <= qj_pend_d;  qk_pend_q <= qk_pend_d;
            type_q <= type_d;  vj_q <= vj_d;  vk_q <= vk_d;  a_q <= a_d;  pc_q <= pc_d;
            qj_q <= qj_d;  qk_q <= qk_d;  dest_q <= dest_d;
            ex_valid_q <= ex_valid_d;  ex_type_q <= ex_type_d;  ex_vj_q <= ex_vj_d;
            ex_vk_q <= ex_vk_d;  ex_a_q <= ex_a_d;  ex_pc_q <= ex_pc_d;  ex_dest_q <= ex_dest_d;
        end
    end

    assign ex_valid = ex_valid_q;
    assign ex_type  = ex_type_q;
    assign ex_vj    = ex_vj_q;
    assign ex_vk    = ex_vk_q;
    assign ex_a     = ex_a_q;
    assign ex_pc    = ex_pc_q;
    assign ex_dest  = ex_dest_q;
endmodule

// File: tb/tb_rs_alu_station.sv
// tb_rs_alu_station: directed scenarios plus randomized traffic, checked every
// cycle against a behavioural model of the station's entry list.
module tb_rs_alu_station;
    logic        clk = 1'b0, rst_n = 1'b0, rdy = 1'b1, clear = 1'b0;
    logic        in_valid = 1'b0, in_qj_busy = 1'b0, in_qk_busy = 1'b0;
    logic [5:0]  in_type = '0;
    logic [31:0] in_vj = '0, in_vk = '0, in_a = '0, in_pc = '0;
    logic [3:0]  in_qj = '0, in_qk = '0, in_dest = '0;
    logic        alu_cdb_v = 1'b0, lsb_cdb_v = 1'b0;
    logic [3:0]  alu_cdb_tag = '0, lsb_cdb_tag = '0;
    logic [31:0] alu_cdb_val = '0, lsb_cdb_val = '0;
    logic        full, ex_valid;
    logic [5:0]  ex_type;
    logic [31:0] ex_vj, ex_vk, ex_a, ex_pc;
    logic [3:0]  ex_dest;

    int vectors = 0, miscompares = 0;

    rs_alu_station dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .clear(clear), .in_valid(in_valid),
        .in_type(in_type), .in_vj(in_vj), .in_vk(in_vk), .in_qj_busy(in_qj_busy),
        .in_qj(in_qj), .in_qk_busy(in_qk_busy), .in_qk(in_qk), .in_a(in_a),
        .in_pc(in_pc), .in_dest(in_dest), .full(full),
        .alu_cdb_v(alu_cdb_v), .alu_cdb_tag(alu_cdb_tag), .alu_cdb_val(alu_cdb_val),
        .lsb_cdb_v(lsb_cdb_v), .lsb_cdb_tag(lsb_cdb_tag), .lsb_cdb_val(lsb_cdb_val),
        .ex_valid(ex_valid), .ex_type(ex_type), .ex_vj(ex_vj), .ex_vk(ex_vk),
        .ex_a(ex_a), .ex_pc(ex_pc), .ex_dest(ex_dest)
    );

    always #5 clk = ~clk;

    // Behavioural model: a list of waiting instructions plus the issue register
    typedef struct {
        bit        busy;
        bit [5:0]  typ;
        bit [31:0] vj, vk, a, pc;
        bit        jp, kp;
        bit [3:0]  qj, qk, dest;
    } ent_t;
    ent_t      m [16];
    bit        e_valid;
    bit [5:0]  e_type;
    bit [31:0] e_vj, e_vk, e_a, e_pc;
    bit [3:0]  e_dest;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m[i].busy = 0;
        e_valid = 0; e_type = 0; e_vj = 0; e_vk = 0; e_a = 0; e_pc = 0; e_dest = 0;
    endtask

    // Value a broadcast would deliver to a waiter on tag t (ALU first), if any
    task automatic bus_lookup(input bit [3:0] t, output bit hit, output bit [31:0] v);
        hit = 0; v = 0;
        if (alu_cdb_v && alu_cdb_tag == t) begin hit = 1; v = alu_cdb_val; end
        else if (lsb_cdb_v && lsb_cdb_tag == t) begin hit = 1; v = lsb_cdb_val; end
    endtask

    task automatic model_step();
        int fs, pk; bit was_full, hit, r; bit [31:0] v; bit pre_rdy [16];
        if (!rst_n) begin model_reset(); return; end
        if (clear) begin
            for (int i = 0; i < 16; i++) m[i].busy = 0;
            e_valid = 0;
            return;
        end
        if (!rdy) return;
        fs = -1; was_full = 1;
        for (int i = 0; i < 16; i++) begin
            if (!m[i].busy) begin was_full = 0; if (fs < 0) fs = i; end
            pre_rdy[i] = m[i].busy && !m[i].jp && !m[i].kp;
        end
        for (int i = 0; i < 16; i++) if (m[i].busy) begin
            if (m[i].jp) begin bus_lookup(m[i].qj, hit, v); if (hit) begin m[i].vj = v; m[i].jp = 0; end end
            if (m[i].kp) begin bus_lookup(m[i].qk, hit, v); if (hit) begin m[i].vk = v; m[i].kp = 0; end end
        end
        pk = -1;
        for (int i = 0; i < 16; i++) begin
`ifdef RS_SAME_CYCLE_WAKE_EN
            r = m[i].busy && !m[i].jp && !m[i].kp;
`else
            r = pre_rdy[i];
`endif
            if (r && pk < 0) pk = i;
        end
        e_valid = (pk >= 0);
        if (pk >= 0) begin
            e_type = m[pk].typ; e_vj = m[pk].vj; e_vk = m[pk].vk;
            e_a = m[pk].a; e_pc = m[pk].pc; e_dest = m[pk].dest;
            m[pk].busy = 0;
        end
        if (in_valid && !was_full) begin
            m[fs].busy = 1; m[fs].typ = in_type; m[fs].a = in_a; m[fs].pc = in_pc;
            m[fs].dest = in_dest; m[fs].qj = in_qj; m[fs].qk = in_qk;
            m[fs].vj = in_vj; m[fs].jp = in_qj_busy; m[fs].vk = in_vk; m[fs].kp = in_qk_busy;
            if (in_qj_busy) begin bus_lookup(in_qj, hit, v); if (hit) begin m[fs].vj = v; m[fs].jp = 0; end end
            if (in_qk_busy) begin bus_lookup(in_qk, hit, v); if (hit) begin m[fs].vk = v; m[fs].kp = 0; end end
        end
    endtask

    function automatic bit model_full();
        bit f = 1;
        for (int i = 0; i < 16; i++) if (!m[i].busy) f = 0;
        return f;
    endfunction

    function automatic bit model_empty();
        bit e = 1;
        for (int i = 0; i < 16; i++) if (m[i].busy) e = 0;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("full", 32'(full), 32'(model_full()));
        check("ex_valid", 32'(ex_valid), 32'(e_valid));
        check("ex_type", 32'(ex_type), 32'(e_type));
        check("ex_vj", ex_vj, e_vj);
        check("ex_vk", ex_vk, e_vk);
        check("ex_a", ex_a, e_a);
        check("ex_pc", ex_pc, e_pc);
        check("ex_dest", 32'(ex_dest), 32'(e_dest));
    endtask

    // One clock: model follows the edge, outputs compared 1ns later
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        $display("cyc t=%0t in_v=%0b full=%0b ex_v=%0b dest=%0d vj=%h vk=%h",
                 $time, in_valid, full, ex_valid, ex_dest, ex_vj, ex_vk);
    endtask

    task automatic idle();
        in_valid = 0; alu_cdb_v = 0; lsb_cdb_v = 0; clear = 0; rdy = 1;
    endtask

    task automatic dispatch(input logic [5:0] t, input logic [31:0] vj, input logic [31:0] vk,
                            input logic jb, input logic [3:0] qj, input logic kb,
                            input logic [3:0] qk, input logic [31:0] a, input logic [3:0] dest);
        in_valid = 1; in_type = t; in_vj = vj; in_vk = vk; in_qj_busy = jb; in_qj = qj;
        in_qk_busy = kb; in_qk = qk; in_a = a; in_pc = {24'h1000, 4'h0, dest}; in_dest = dest;
    endtask

    task automatic wait_issue(input string name, input int budget);
        int n = 0;
        while (!ex_valid && n < budget) begin cycle(); n++; end
        check({name, "_issue_timeout"}, 32'(ex_valid), 32'd1);
    endtask

    initial begin
        model_reset();
        idle();
        repeat (2) cycle();
        // Reset state
        check("rst_full", 32'(full), 32'd0);
        check("rst_ex_valid", 32'(ex_valid), 32'd0);
        check("rst_ex_vj", ex_vj, 32'd0);
        rst_n = 1;
        cycle();

        // ADD with both operands ready
        dispatch(6'h01, 32'd5, 32'd7, 0, 4'd0, 0, 4'd0, 32'd0, 4'd3);
        cycle(); idle();
        check("add_lat1", 32'(ex_valid), 32'd0);
        cycle();
        check("add_valid", 32'(ex_valid), 32'd1);
        check("add_type", 32'(ex_type), 32'h01);
        check("add_vj", ex_vj, 32'd5);
        check("add_vk", ex_vk, 32'd7);
        check("add_dest", 32'(ex_dest), 32'd3);
        cycle();
        check("add_drop", 32'(ex_valid), 32'd0);

        // ADDI waiting on tag 9; tag 8 must not wake it
        dispatch(6'h02, 32'd0, 32'd0, 1, 4'd9, 0, 4'd0, 32'd4, 4'd5);
        cycle(); idle(); cycle();
        alu_cdb_v = 1; alu_cdb_tag = 4'd8; alu_cdb_val = 32'h99;
        cycle();
        check("addi_tag8_ignored", 32'(ex_valid), 32'd0);
        alu_cdb_tag = 4'd9; alu_cdb_val = 32'h10;
        cycle(); idle();
        wait_issue("addi", 3);
        check("addi_vj", ex_vj, 32'h10);
        check("addi_a", ex_a, 32'd4);
        check("addi_dest", 32'(ex_dest), 32'd5);
        cycle();

        // Dispatch bypass from the LSB bus
        dispatch(6'h03, 32'd0, 32'd1, 1, 4'd2, 0, 4'd0, 32'd0, 4'd6);
        lsb_cdb_v = 1; lsb_cdb_tag = 4'd2; lsb_cdb_val = 32'hFFFF_FFFF;
        cycle(); idle(); cycle();
        check("byp_valid", 32'(ex_valid), 32'd1);
        check("byp_vj", ex_vj, 32'hFFFF_FFFF);
        // Both buses fill one entry on the same edge
        dispatch(6'h04, 32'd0, 32'd0, 1, 4'd1, 1, 4'd5, 32'd0, 4'd7);
        cycle(); idle();
        alu_cdb_v = 1; alu_cdb_tag = 4'd1; alu_cdb_val = 32'hA;
        lsb_cdb_v = 1; lsb_cdb_tag = 4'd5; lsb_cdb_val = 32'hB;
        cycle(); idle();
        wait_issue("dual", 3);
        check("dual_vj", ex_vj, 32'hA);
        check("dual_vk", ex_vk, 32'hB);
        check("dual_dest", 32'(ex_dest), 32'd7);
        cycle();

        // Fill all 16 entries, 17th dispatch ignored
        for (int i = 0; i < 16; i++) begin
            dispatch(6'h05, 32'd0, 32'd0, 1, i[3:0], 0, 4'd0, 32'd0, i[3:0]);
            cycle();
        end
        check("fill_full", 32'(full), 32'd1);
        dispatch(6'h06, 32'h1717, 32'd0, 0, 4'd0, 0, 4'd0, 32'd0, 4'd15);
        cycle(); idle();
        check("fill_17th_blocked", 32'(full), 32'd1);
        alu_cdb_v = 1; alu_cdb_tag = 4'd0; alu_cdb_val = 32'h50;
        cycle(); idle();
        wait_issue("fill_e0", 3);
        check("fill_e0_dest", 32'(ex_dest), 32'd0);
        check("fill_e0_vj", ex_vj, 32'h50);
        check("fill_drop_full", 32'(full), 32'd0);
        dispatch(6'h07, 32'hAA, 32'd0, 0, 4'd0, 0, 4'd0, 32'd0, 4'd10);
        cycle(); idle();
        wait_issue("refill", 3);
        check("refill_vj", ex_vj, 32'hAA);
        for (int t = 1; t < 16; t++) begin
            alu_cdb_v = 1; alu_cdb_tag = t[3:0]; alu_cdb_val = 32'(t) + 32'h100;
            cycle();
        end
        idle();
        repeat (20) cycle();
        check("drain_empty", 32'(full), 32'd0);

        // Flush with a ready entry selected
        for (int i = 0; i < 4; i++) begin
            dispatch(6'h08, 32'd0, 32'd0, 1, 4'd7, 0, 4'd0, 32'd0, 4'(i + 1));
            cycle();
        end
        dispatch(6'h09, 32'h33, 32'd0, 0, 4'd0, 0, 4'd0, 32'd0, 4'd9);
        cycle(); idle();
        clear = 1;
        cycle(); idle();
        check("clr_valid", 32'(ex_valid), 32'd0);
        check("clr_full", 32'(full), 32'd0);
        alu_cdb_v = 1; alu_cdb_tag = 4'd7; alu_cdb_val = 32'h77;
        cycle(); idle(); cycle();
        check("clr_no_stale", 32'(ex_valid), 32'd0);
        // rdy=0 freezes everything
        dispatch(6'h0A, 32'h44, 32'd0, 0, 4'd0, 0, 4'd0, 32'd0, 4'd2);
        cycle(); idle(); cycle(); cycle();
        dispatch(6'h0B, 32'h55, 32'd0, 0, 4'd0, 0, 4'd0, 32'd0, 4'd3);
        rdy = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("frz_vj", ex_vj, 32'h44);
            check("frz_valid", 32'(ex_valid), 32'd0);
        end
        idle(); cycle(); cycle();
        check("frz_no_accept", 32'(ex_valid), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rdy = ($urandom_range(9) != 0);
            clear = ($urandom_range(39) == 0);
            in_valid = $urandom_range(1);
            in_type = 6'($urandom); in_vj = $urandom; in_vk = $urandom;
            in_qj_busy = $urandom_range(1); in_qj = 4'($urandom);
            in_qk_busy = $urandom_range(1); in_qk = 4'($urandom);
            in_a = $urandom; in_pc = $urandom; in_dest = 4'($urandom);
            alu_cdb_v = rdy && ($urandom_range(9) < 5);
            alu_cdb_tag = 4'($urandom); alu_cdb_val = $urandom;
            lsb_cdb_v = rdy && ($urandom_range(9) < 4);
            lsb_cdb_tag = ($urandom_range(3) == 0) ? alu_cdb_tag : 4'($urandom);
            lsb_cdb_val = $urandom;
            cycle();
        end
        idle();
        for (int n = 0; n < 200 && !model_empty(); n++) begin
            alu_cdb_v = 1; alu_cdb_tag = 4'(n); alu_cdb_val = $urandom;
            cycle();
        end
        idle();
        repeat (4) cycle();

        // Reset in the middle of traffic
        for (int i = 0; i < 3; i++) begin
            dispatch(6'h0C, 32'd0, 32'd0, 1, 4'd14, 0, 4'd0, 32'd0, 4'(i));
            cycle();
        end
        dispatch(6'h0D, 32'h66, 32'h67, 0, 4'd0, 0, 4'd0, 32'd1, 4'd11);
        cycle(); idle(); cycle();
        check("pre_rst_valid", 32'(ex_valid), 32'd1);
        #3 rst_n = 0;
        #1;
        model_reset();
        check("arst_full", 32'(full), 32'd0);
        check("arst_valid", 32'(ex_valid), 32'd0);
        check("arst_vj", ex_vj, 32'd0);
        check("arst_dest", 32'(ex_dest), 32'd0);
        cycle(); cycle();
        rst_n = 1;
        alu_cdb_v = 1; alu_cdb_tag = 4'd14; alu_cdb_val = 32'hEE;
        cycle(); idle();
        repeat (3) cycle();
        check("post_rst_no_issue", 32'(ex_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog so the run can never hang
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
